fmul_round_pack: RTL

//  Output stage directly downstream of the FP32 multiplier core.
//  - Consumes the core's unpacked result {sign, exp, frac, error, overflow} plus a sticky bit.
//  - Rounds, handles exceptions and packs an IEEE-754 binary32 word with exception flags.
//  - 2-stage valid/ready pipeline, 1 result/cycle; back-pressure from the consumer propagates to the core.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fp32_round_inc.sv | 15 +
 rtl/fmul_round_pack.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 constants for the multiplier/adder output stages.
package fpu_pkg;
  localparam int EXP_MAX  = 255;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

  // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag vector
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam int ROUND_RNE = 0;
  localparam int ROUND_RTZ = 1;
endpackage

// File: rtl/fp32_round_inc.sv
// Rounding-increment decision for a 23-bit mantissa with guard/sticky.
module fp32_round_inc
  import fpu_pkg::*;
(
  input  logic [22:0] mant,
  input  logic        g,
  input  logic        s,
  input  logic        mode,
  output logic        inc,
  output logic        carry
);
  // mode: 0 = nearest-even, 1 = toward zero (never increments)
  assign inc   = !mode & g & (s | mant[0]);
  assign carry = inc & (&mant);
endmodule

// File: rtl/fmul_round_pack.sv
// FP32 multiplier output stage: round, resolve exceptions, pack, with a 2-stage valid/ready pipe.
// Optional build macro FMUL_RP_STICKY_FLAGS_EN adds flag_clr / sticky_flags accumulation.
module fmul_round_pack
  import fpu_pkg::*;
#(
  parameter int          ROUND_MODE = ROUND_RNE,
  parameter logic [31:0] QNAN       = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [23:0] in_frac,
  input  logic        in_sticky,
  input  logic        in_error,
  input  logic        in_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags
`ifdef FMUL_RP_STICKY_FLAGS_EN
  ,
  input  logic        flag_clr,
  output logic [3:0]  sticky_flags
`endif
);
  localparam logic RMODE = (ROUND_MODE == ROUND_RTZ);

  logic        r_s1_valid, r_s1_sign, r_s1_inc, r_s1_carry, r_s1_err, r_s1_ovf, r_s1_gs;
  logic [7:0]  r_s1_exp;
  logic [22:0] r_s1_mant;
  logic        r_s2_valid;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_flags;

  logic        w_s1_adv, w_s2_adv, w_inc, w_carry;
  logic [22:0] w_mant_rnd;
  logic [8:0]  w_exp_rnd;
  logic [31:0] w_data;
  logic [3:0]  w_flags;

  assign w_s2_adv = !r_s2_valid | out_ready;
  assign w_s1_adv = !r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv & !rst;

  fp32_round_inc u_round_inc (
    .mant  (in_frac[23:1]),
    .g     (in_frac[0]),
    .s     (in_sticky),
    .mode  (RMODE),
    .inc   (w_inc),
    .carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_inc   <= 1'b0;
      r_s1_carry <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_gs    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= in_sign;
        r_s1_exp   <= in_exp;
        r_s1_mant  <= in_frac[23:1];
        r_s1_inc   <= w_inc;
        r_s1_carry <= w_carry;
        r_s1_err   <= in_error;
        r_s1_ovf   <= in_overflow;
        r_s1_gs    <= in_frac[0] | in_sticky;
      end
    end
  end

  // Mantissa wraps to zero exactly when the increment carries out, which is the renormalised value.
  assign w_mant_rnd = r_s1_mant + {22'b0, r_s1_inc};
  assign w_exp_rnd  = {1'b0, r_s1_exp} + {8'b0, r_s1_carry};

  always_comb begin
    w_data  = '0;
    w_flags = '0;
    if (r_s1_err) begin
      w_data           = QNAN;
      w_flags[FLG_INV] = 1'b1;
    end else if (r_s1_ovf) begin
      w_data           = {r_s1_sign, 8'hFF, 23'h0};
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else if (r_s1_exp == 8'h00) begin
      w_data           = {r_s1_sign, 31'h0};
      w_flags[FLG_UNF] = 1'b1;
      w_flags[FLG_INX] = (|r_s1_mant) | r_s1_gs;
    end else if (w_exp_rnd >= 9'(EXP_MAX)) begin
      w_data           = {r_s1_sign, 8'hFF, 23'h0};
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_data           = {r_s1_sign, w_exp_rnd[7:0], w_mant_rnd};
      w_flags[FLG_INX] = r_s1_gs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_data;
        r_out_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

`ifdef FMUL_RP_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  // A flag arriving in the same cycle as a clear survives it.
  always_ff @(posedge clk) begin
    if (rst) r_sticky <= '0;
    else     r_sticky <= (flag_clr ? 4'h0 : r_sticky) |
                         ((r_s2_valid & out_ready) ? r_out_flags : 4'h0);
  end

  assign sticky_flags = r_sticky;
`endif
endmodule
